// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with built-in load-use hazard detection; 1-cycle ID->EX latency.
// Backpressure: hold_i freezes all state; a load-use hazard raises stall_o upstream and inserts one bubble.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              ID_Valid_i,
    input  logic [REG_AW-1:0] ID_RS1_i,
    input  logic [REG_AW-1:0] ID_RS2_i,
    input  logic [REG_AW-1:0] ID_Rd_i,
    input  logic              ID_UsesRS1_i,
    input  logic              ID_UsesRS2_i,
    input  logic [DATA_W-1:0] ID_RS1data_i,
    input  logic [DATA_W-1:0] ID_RS2data_i,
    input  logic [DATA_W-1:0] ID_Imm_i,
    input  logic [9:0]        ID_Funct_i,
    input  logic              ID_RegWrite_i,
    input  logic              ID_MemtoReg_i,
    input  logic              ID_MemRead_i,
    input  logic              ID_MemWrite_i,
    input  logic              ID_ALUSrc_i,
    input  logic [1:0]        ID_ALUOp_i,
    output logic              EX_Valid_o,
    output logic [REG_AW-1:0] EX_RS1_o,
    output logic [REG_AW-1:0] EX_RS2_o,
    output logic [REG_AW-1:0] EX_Rd_o,
    output logic              EX_UsesRS1_o,
    output logic              EX_UsesRS2_o,
    output logic [DATA_W-1:0] EX_RS1data_o,
    output logic [DATA_W-1:0] EX_RS2data_o,
    output logic [DATA_W-1:0] EX_Imm_o,
    output logic [9:0]        EX_Funct_o,
    output logic              EX_RegWrite_o,
    output logic              EX_MemtoReg_o,
    output logic              EX_MemRead_o,
    output logic              EX_MemWrite_o,
    output logic              EX_ALUSrc_o,
    output logic [1:0]        EX_ALUOp_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              valid_q, valid_d;
    logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic              uses_rs1_q, uses_rs1_d, uses_rs2_q, uses_rs2_d;
    logic [DATA_W-1:0] rs1data_q, rs1data_d, rs2data_q, rs2data_d, imm_q, imm_d;
    logic [9:0]        funct_q, funct_d;
    logic              regwrite_q, regwrite_d, memtoreg_q, memtoreg_d;
    logic              memread_q, memread_d, memwrite_q, memwrite_d, alusrc_q, alusrc_d;
    logic [1:0]        aluop_q, aluop_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              haz;

    // Bubbles carry Rd=0 and MemRead=0, so a bubble in EX can never match here.
    assign haz = valid_q & memread_q & (rd_q != '0) & ID_Valid_i &
                 ((ID_UsesRS1_i & (ID_RS1_i == rd_q)) | (ID_UsesRS2_i & (ID_RS2_i == rd_q)));
    assign stall_o = haz & ~flush_i;

    always_comb begin
        valid_d    = valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        uses_rs1_d = uses_rs1_q;
        uses_rs2_d = uses_rs2_q;
        rs1data_d  = rs1data_q;
        rs2data_d  = rs2data_q;
        imm_d      = imm_q;
        funct_d    = funct_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        alusrc_d   = alusrc_q;
        aluop_d    = aluop_q;
        cnt_d      = cnt_q;
        if (!hold_i) begin
            if (flush_i || haz) begin
                valid_d    = 1'b0;
                rs1_d      = '0;
                rs2_d      = '0;
                rd_d       = '0;
                uses_rs1_d = 1'b0;
                uses_rs2_d = 1'b0;
                rs1data_d  = '0;
                rs2data_d  = '0;
                imm_d      = '0;
                funct_d    = '0;
                regwrite_d = 1'b0;
                memtoreg_d = 1'b0;
                memread_d  = 1'b0;
                memwrite_d = 1'b0;
                alusrc_d   = 1'b0;
                aluop_d    = '0;
            end else begin
                valid_d    = ID_Valid_i;
                rs1_d      = ID_RS1_i;
                rs2_d      = ID_RS2_i;
                rd_d       = ID_Rd_i;
                uses_rs1_d = ID_UsesRS1_i;
                uses_rs2_d = ID_UsesRS2_i;
                rs1data_d  = ID_RS1data_i;
                rs2data_d  = ID_RS2data_i;
                imm_d      = ID_Imm_i;
                funct_d    = ID_Funct_i;
                regwrite_d = ID_RegWrite_i & ID_Valid_i;
                memtoreg_d = ID_MemtoReg_i & ID_Valid_i;
                memread_d  = ID_MemRead_i & ID_Valid_i;
                memwrite_d = ID_MemWrite_i & ID_Valid_i;
                alusrc_d   = ID_ALUSrc_i & ID_Valid_i;
                aluop_d    = ID_ALUOp_i & {2{ID_Valid_i}};
            end
            if (stall_o && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            uses_rs1_q <= 1'b0;
            uses_rs2_q <= 1'b0;
            rs1data_q  <= '0;
            rs2data_q  <= '0;
            imm_q      <= '0;
            funct_q    <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            alusrc_q   <= 1'b0;
            aluop_q    <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            uses_rs1_q <= uses_rs1_d;
            uses_rs2_q <= uses_rs2_d;
            rs1data_q  <= rs1data_d;
            rs2data_q  <= rs2data_d;
            imm_q      <= imm_d;
            funct_q    <= funct_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            alusrc_q   <= alusrc_d;
            aluop_q    <= aluop_d;
            cnt_q      <= cnt_d;
        end
    end

    assign EX_Valid_o    = valid_q;
    assign EX_RS1_o      = rs1_q;
    assign EX_RS2_o      = rs2_q;
    assign EX_Rd_o       = rd_q;
    assign EX_UsesRS1_o  = uses_rs1_q;
    assign EX_UsesRS2_o  = uses_rs2_q;
    assign EX_RS1data_o  = rs1data_q;
    assign EX_RS2data_o  = rs2data_q;
    assign EX_Imm_o      = imm_q;
    assign EX_Funct_o    = funct_q;
    assign EX_RegWrite_o = regwrite_q;
    assign EX_MemtoReg_o = memtoreg_q;
    assign EX_MemRead_o  = memread_q;
    assign EX_MemWrite_o = memwrite_q;
    assign EX_ALUSrc_o   = alusrc_q;
    assign EX_ALUOp_o    = aluop_q;
    assign stall_cnt_o   = cnt_q;

endmodule
